mem_port_arbiter: RTL

Two-requester arbiter that shares the single synchronous memory port (inst_mem) between the processor's ADDR/DOUT/W path and a second master, such as a program loader or DMA engine. It grants one request per cycle using round-robin fairness, with an optional bounded burst lock. It drives the memory address, data and write-enable, and routes returned read data, tagged with a valid strobe, back to whichever requester issued the read. It sits between the processor/loader and inst_mem in the top level.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single synchronous memory port,
// with bounded burst locking and per-requester read-data return tracking.
module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_50MHz,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    lock,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    logic              last_q, last_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q, id_d;

    logic gnt_any;
    logic win;
    logic win_we;
    logic locked;

    // bcnt is non-zero exactly when the previous cycle produced a grant, and
    // that grant went to last_q, so it doubles as the "granted last cycle" flag.
    always_comb begin
        locked  = req[last_q] && lock[last_q] && (bcnt_q != '0) && (bcnt_q < BMAX);
        gnt_any = (req != 2'b00) && !reset;

        win = 1'b0;
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = locked ? last_q : ~last_q;
            default: win = 1'b0;
        endcase

        gnt      = 2'b00;
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        win_we   = 1'b0;
        if (gnt_any) begin
            gnt      = win ? 2'b10 : 2'b01;
            mem_addr = win ? addr1 : addr0;
            mem_data = win ? wdata1 : wdata0;
            win_we   = we[win];
            mem_wren = win_we;
        end

        last_d = last_q;
        bcnt_d = '0;
        if (gnt_any) begin
            last_d = win;
            if ((bcnt_q != '0) && (win == last_q)) begin
                bcnt_d = (bcnt_q == BMAX) ? bcnt_q : bcnt_q + BW'(1);
            end else begin
                bcnt_d = BW'(1);
            end
        end
    end

    // Read-return pipeline: stage 0 captures the granted read, the tail
    // lines up with mem_q for that address.
    assign vld_d[0] = gnt_any & ~win_we;
    assign id_d[0]  = win;

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
            assign vld_d[gi] = vld_q[gi-1];
            assign id_d[gi]  = id_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
            bcnt_q <= '0;
            vld_q  <= '0;
            id_q   <= '0;
        end else begin
            last_q <= last_d;
            bcnt_q <= bcnt_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
        end
    end

    always_comb begin
        rvalid = 2'b00;
        rdata  = '0;
        if (vld_q[RD_LAT-1]) begin
            rvalid = id_q[RD_LAT-1] ? 2'b10 : 2'b01;
            rdata  = mem_q;
        end
    end

endmodule
